// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with optional two-entry skid buffer.
// out_data comes straight from the main register and reads NOP_VALUE whenever the stage is empty.
module pipe_stage_reg #(
  parameter int unsigned          DATA_W    = 166,
  parameter bit                   SKID      = 1'b1,
  parameter logic [DATA_W-1:0]    NOP_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StTwo = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q;
  logic              push, pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;
  assign occupancy = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush) begin
      state_d = StEmpty;
      main_d  = NOP_VALUE;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            state_d = StOne;
            main_d  = in_data;
          end
        end
        StOne: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push && SKID) begin
            state_d = StTwo;
          end else if (pop) begin
            state_d = StEmpty;
            main_d  = NOP_VALUE;
          end
        end
        StTwo: begin
          if (pop) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  if (SKID) begin : g_skid
    logic [DATA_W-1:0] skid_d;
    logic              in_ready_q;

    always_comb begin
      skid_d = skid_q;
      if (flush) begin
        skid_d = NOP_VALUE;
      end else if (state_q == StOne && push && !pop) begin
        skid_d = in_data;
      end else if (state_q == StTwo && pop) begin
        skid_d = NOP_VALUE;
      end
    end

    // Ready is a flop of the next state, so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk) begin
      if (rst) begin
        skid_q     <= NOP_VALUE;
        in_ready_q <= 1'b1;
      end else begin
        skid_q     <= skid_d;
        in_ready_q <= (state_d != StTwo);
      end
    end

    assign in_ready = in_ready_q;
  end else begin : g_no_skid
    assign skid_q   = NOP_VALUE;
    assign in_ready = !out_valid | out_ready;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid variant at default width, plus an 8-bit
// no-skid variant with a non-zero bubble value.
module tb_pipe_stage_reg;

  localparam int unsigned W  = 166;
  localparam int unsigned W0 = 8;
  localparam logic [W0-1:0] NOP0 = 8'hEE;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [1:0]    occupancy;
  logic          in_valid0, in_ready0, out_valid0, out_ready0;
  logic [W0-1:0] in_data0, out_data0;
  logic [1:0]    occupancy0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  pipe_stage_reg #(.DATA_W(W0), .SKID(1'b0), .NOP_VALUE(NOP0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .in_data   (in_data0),
    .out_valid (out_valid0),
    .out_ready (out_ready0),
    .out_data  (out_data0),
    .occupancy (occupancy0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total_cnt++; if (occupancy !== 2'd0) $display("FAIL reset_occ: got %0d want 0", occupancy); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== '0) $display("FAIL reset_data: got %h want 0", out_data); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_data0 !== NOP0) $display("FAIL reset_data0: got %h want ee", out_data0); else pass_cnt++;
    total_cnt++; if (occupancy0 !== 2'd0) $display("FAIL reset_occ0: got %0d want 0", occupancy0); else pass_cnt++;
  endtask

  task automatic test_streaming();
    logic [W-1:0] exp;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = W'(i);
      tick();
      exp = W'(i);
      total_cnt++; if (out_data !== exp) $display("FAIL stream_data%0d: got %h want %h", i, out_data, exp); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b1 || occupancy !== 2'd1 || in_ready !== 1'b1)
        $display("FAIL stream_ctl%0d: got v=%b occ=%0d rdy=%b want v=1 occ=1 rdy=1", i, out_valid, occupancy, in_ready);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    tick();
    total_cnt++; if (occupancy !== 2'd0 || out_data !== '0)
      $display("FAIL stream_drain: got occ=%0d data=%h want occ=0 data=0", occupancy, out_data);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'('hA);
    tick();
    in_data = W'('hB);
    tick();
    in_valid = 1'b0; in_data = W'('hF);
    total_cnt++; if (occupancy !== 2'd2) $display("FAIL bp_occ2: got %0d want 2", occupancy); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready: got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (out_data !== W'('hA)) $display("FAIL bp_head: got %h want a", out_data); else pass_cnt++;
    tick();
    total_cnt++; if (out_data !== W'('hA) || occupancy !== 2'd2)
      $display("FAIL bp_hold: got data=%h occ=%0d want data=a occ=2", out_data, occupancy);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    total_cnt++; if (out_data !== W'('hB) || occupancy !== 2'd1)
      $display("FAIL bp_second: got data=%h occ=%0d want data=b occ=1", out_data, occupancy);
    else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", in_ready); else pass_cnt++;
    tick();
    total_cnt++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== '0)
      $display("FAIL bp_empty: got occ=%0d v=%b data=%h want 0 0 0", occupancy, out_valid, out_data);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'('hA);
    tick();
    in_data = W'('hB);
    tick();
    flush = 1'b1; in_data = W'('hC);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total_cnt++; if (occupancy !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL flush_state: got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid);
    else pass_cnt++;
    total_cnt++; if (out_data !== '0) $display("FAIL flush_data: got %h want 0", out_data); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1)
      $display("FAIL flush_no_c: got v=%b data=%h rdy=%b want 0 0 1", out_valid, out_data, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_push_pop_one();
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'('h5);
    tick();
    total_cnt++; if (out_data !== W'('h5)) $display("FAIL pp_first: got %h want 5", out_data); else pass_cnt++;
    in_data = W'('h6); out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total_cnt++; if (out_data !== W'('h6) || occupancy !== 2'd1)
      $display("FAIL pp_swap: got data=%h occ=%0d want data=6 occ=1", out_data, occupancy);
    else pass_cnt++;
    tick();
    total_cnt++; if (occupancy !== 2'd0) $display("FAIL pp_drain: got %0d want 0", occupancy); else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'('h21);
    tick();
    in_data = W'('h22);
    tick();
    total_cnt++; if (occupancy !== 2'd2) $display("FAIL rm_full: got %0d want 2", occupancy); else pass_cnt++;
    rst = 1'b1; in_data = W'('h23);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    total_cnt++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== '0)
      $display("FAIL rm_state: got occ=%0d v=%b data=%h want 0 0 0", occupancy, out_valid, out_data);
    else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rm_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_no_skid();
    out_ready0 = 1'b0; in_valid0 = 1'b1; in_data0 = 8'h11;
    tick();
    in_data0 = 8'h22;
    total_cnt++; if (in_ready0 !== 1'b0) $display("FAIL ns_ready_low: got %b want 0", in_ready0); else pass_cnt++;
    tick();
    total_cnt++; if (occupancy0 !== 2'd1 || out_data0 !== 8'h11)
      $display("FAIL ns_hold: got occ=%0d data=%h want occ=1 data=11", occupancy0, out_data0);
    else pass_cnt++;
    out_ready0 = 1'b1;
    #1;
    total_cnt++; if (in_ready0 !== 1'b1) $display("FAIL ns_ready_comb: got %b want 1", in_ready0); else pass_cnt++;
    tick();
    in_valid0 = 1'b0;
    total_cnt++; if (out_data0 !== 8'h22 || occupancy0 !== 2'd1)
      $display("FAIL ns_swap: got data=%h occ=%0d want data=22 occ=1", out_data0, occupancy0);
    else pass_cnt++;
    tick();
    total_cnt++; if (out_valid0 !== 1'b0 || out_data0 !== NOP0)
      $display("FAIL ns_empty: got v=%b data=%h want v=0 data=ee", out_valid0, out_data0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_push_pop_one();
    test_reset_midstream();
    test_no_skid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // The no-skid variant must never report two entries.
  always @(negedge clk) begin
    if (!rst && occupancy0 > 2'd1) begin
      total_cnt++;
      $display("FAIL ns_occ_max: got %0d want <=1", occupancy0);
    end
  end

endmodule
